a0_trace: RTL

Downstream observer for the single-cycle CPU top: samples the CPU's `a0` result register every cycle and records each change of value as a time-stamped entry. Entries sit in a small FIFO and drain over a valid/ready handshake to a display, UART or testbench sink. It does not feed back into the CPU and never stalls it. The CPU runs at full rate, and a slow sink causes dropped entries, flagged by a sticky overflow.

---
 rtl/a0_trace.sv | 94 +++++++++
 1 files changed

// File: rtl/a0_trace.sv
// rtl/a0_trace.sv - a0 change tracer with time-stamped entry FIFO and sticky overflow
module a0_trace #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int STAMP_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DATA_WIDTH-1:0]      a0,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [STAMP_WIDTH-1:0]     out_stamp,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = STAMP_WIDTH + DATA_WIDTH;

  logic [EW-1:0]          mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [STAMP_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  prev_q, prev_d;
  logic                   primed_q, primed_d;

  logic push_req, push_ok, pop;
  logic [EW-1:0] head;

  assign pop      = (level_q != '0) && out_ready;
  assign push_req = en && (!primed_q || (a0 != prev_q));
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok  = push_req && ((level_q < LW'(DEPTH)) || pop);

  always_comb begin
    cnt_d      = cnt_q + STAMP_WIDTH'(1);
    prev_d     = prev_q;
    primed_d   = primed_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (en) begin
      prev_d   = a0;
      primed_d = 1'b1;
    end
    if (push_req && !push_ok) overflow_d = 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      prev_q     <= '0;
      primed_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      primed_q   <= primed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= {cnt_q, a0};
  end

  assign head      = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign out_valid = (level_q != '0);
  assign out_stamp = head[EW-1:DATA_WIDTH];
  assign out_data  = head[DATA_WIDTH-1:0];
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule
